// File: rtl/dmem_pkg.sv
// Shared types and width helpers for the wait-state data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } dmem_state_e;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DEPTH       = 64;
  localparam int DEF_WAIT_CYCLES = 2;

  function automatic int word_bytes(input int data_w);
    return data_w / 8;
  endfunction

  // Number of byte-offset bits below the word index in a byte address.
  function automatic int off_width(input int data_w);
    return $clog2(word_bytes(data_w));
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: byte-enabled bus write, full-word backdoor write, async read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = idx_width(DEF_DEPTH)
) (
  input  logic                clk_i,
  input  logic                bus_we_i,
  input  logic [IDX_W-1:0]    bus_idx_i,
  input  logic [DATA_W-1:0]   bus_wdata_i,
  input  logic [DATA_W/8-1:0] bus_be_i,
  input  logic                init_we_i,
  input  logic [IDX_W-1:0]    init_idx_i,
  input  logic [DATA_W-1:0]   init_data_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic [DATA_W-1:0]   rd_data_o
);

  localparam int BYTES = word_bytes(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              init_ok;

  if ((1 << IDX_W) > DEPTH) begin : g_init_chk
    assign init_ok = (init_idx_i < IDX_W'(DEPTH));
  end else begin : g_init_nochk
    assign init_ok = 1'b1;
  end

  // Bus bytes are assigned last so they override the backdoor word on a collision.
  always_ff @(posedge clk_i) begin
    if (init_we_i && init_ok) begin
      mem_q[init_idx_i] <= init_data_i;
    end
    if (bus_we_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus_be_i[b]) begin
          mem_q[bus_idx_i][b*8 +: 8] <= bus_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/dmem_ws.sv
// Data memory with programmable wait states, req/ready handshake,
// byte-lane writes, alignment/range error reporting and a backdoor preload port.
module dmem_ws
  import dmem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                         clk_i,
  input  logic                         rst_n,
  input  logic                         req_i,
  input  logic                         we_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [DATA_W/8-1:0]          be_i,
  output logic                         ready_o,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         err_o,
  output logic                         busy_o,
  input  logic                         init_we_i,
  input  logic [idx_width(DEPTH)-1:0]  init_idx_i,
  input  logic [DATA_W-1:0]            init_data_i
);

  localparam int BYTES = word_bytes(DATA_W);
  localparam int OFF_W = off_width(DATA_W);
  localparam int IDX_W = idx_width(DEPTH);
  localparam int CNT_W = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(BYTES - 1);

  dmem_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [BYTES-1:0]     be_q;
  logic                 ready_q;
  logic                 err_q;
  logic [DATA_W-1:0]    rdata_q;

  logic                 accept;
  logic                 misaligned;
  logic                 out_of_range;
  logic                 acc_err;
  logic [ADDR_W-1:0]    idx_full;
  logic [IDX_W-1:0]     word_idx;
  logic                 bus_we;
  logic [DATA_W-1:0]    rd_data;

  assign accept       = (state_q == IDLE) && req_i;
  assign idx_full     = addr_q >> OFF_W;
  assign misaligned   = (addr_q & OFF_MASK) != '0;
  assign out_of_range = idx_full >= ADDR_W'(DEPTH);
  assign acc_err      = misaligned || out_of_range;
  assign word_idx     = idx_full[IDX_W-1:0];
  assign bus_we       = (state_q == ACCESS) && we_q && !acc_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      we_q    <= we_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      be_q    <= be_i;
    end
  end

  // The response is registered at the end of ACCESS, so ready lands in the
  // following IDLE cycle, which is also the last cycle busy stays high.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= (state_q == ACCESS);
      err_q   <= (state_q == ACCESS) && acc_err;
      if (state_q == ACCESS) begin
        if (acc_err) begin
          rdata_q <= '0;
        end else if (!we_q) begin
          rdata_q <= rd_data;
        end
      end
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i       (clk_i),
    .bus_we_i    (bus_we),
    .bus_idx_i   (word_idx),
    .bus_wdata_i (wdata_q),
    .bus_be_i    (be_q),
    .init_we_i   (init_we_i),
    .init_idx_i  (init_idx_i),
    .init_data_i (init_data_i),
    .rd_idx_i    (word_idx),
    .rd_data_o   (rd_data)
  );

  assign ready_o = ready_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;
  assign busy_o  = (state_q != IDLE) || ready_q;

endmodule

// File: tb/tb_dmem_ws.sv
// Directed bench for dmem_ws: a WAIT_CYCLES=2 instance for the main table and
// corner sequences, plus a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dmem_ws;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req0, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        init_we;
  logic [5:0]  init_idx;
  logic [31:0] init_data;

  logic        ready2, err2, busy2;
  logic [31:0] rdata2;
  logic        ready0, err0, busy0;
  logic [31:0] rdata0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(2)) u_w2 (
    .clk_i(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .ready_o(ready2), .rdata_o(rdata2),
    .err_o(err2), .busy_o(busy2), .init_we_i(init_we), .init_idx_i(init_idx),
    .init_data_i(init_data)
  );

  dmem_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_n(rst_n), .req_i(req0), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .ready_o(ready0), .rdata_o(rdata0),
    .err_o(err0), .busy_o(busy0), .init_we_i(init_we), .init_idx_i(init_idx),
    .init_data_i(init_data)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    init_we   = 1'b1;
    init_idx  = idx[5:0];
    init_data = d;
    @(negedge clk);
    init_we   = 1'b0;
  endtask

  // Returns at the negedge following the accepting edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    be    = b;
    @(negedge clk);
    req   = 1'b0;
  endtask

  // Counts edges after acceptance until ready2 is seen; gives up at 20.
  task automatic wait_ready(output int lat);
    lat = 0;
    while (ready2 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int          lat;
    int          cnt;
    logic [7:0]  rdy_pat, busy_pat;

    rst_n = 1'b0; req = 1'b0; req0 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    be = '0; init_we = 1'b0; init_idx = '0; init_data = '0;

    vecs[0]  = '{1'b0, 32'h04,  32'h0,        4'h0, 32'h00000005, 1'b0};
    vecs[1]  = '{1'b0, 32'h08,  32'h0,        4'h0, 32'h0000000A, 1'b0};
    vecs[2]  = '{1'b1, 32'h0C,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h0C,  32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[4]  = '{1'b0, 32'h06,  32'h0,        4'h0, 32'h0,        1'b1};
    vecs[5]  = '{1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 32'h00,  32'h0,        4'h0, 32'hCAFE0000, 1'b0};
    vecs[7]  = '{1'b1, 32'h00,  32'h12345678, 4'h0, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'h00,  32'h0,        4'hF, 32'hCAFE0000, 1'b0};
    vecs[9]  = '{1'b0, 32'hFC,  32'h0,        4'h0, 32'h3F3F3F3F, 1'b0};
    vecs[10] = '{1'b1, 32'hFC,  32'hA5000000, 4'h8, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'hFC,  32'h0,        4'h0, 32'hA53F3F3F, 1'b0};
    vecs[12] = '{1'b0, 32'hFE,  32'h0,        4'h0, 32'h0,        1'b1};
    vecs[13] = '{1'b0, 32'h100, 32'h0,        4'h0, 32'h0,        1'b1};

    repeat (2) @(negedge clk);
    check("reset_ready", {31'b0, ready2}, 32'h0);
    check("reset_busy",  {31'b0, busy2},  32'h0);
    check("reset_err",   {31'b0, err2},   32'h0);
    check("reset_rdata", rdata2,          32'h0);
    rst_n = 1'b1;

    preload(0,  32'hCAFE0000);
    preload(1,  32'h00000005);
    preload(2,  32'h0000000A);
    preload(3,  32'h11223344);
    preload(63, 32'h3F3F3F3F);

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      wait_ready(lat);
      check($sformatf("v%0d_latency", i), lat, 32'd3);
      check($sformatf("v%0d_err", i), {31'b0, err2}, {31'b0, vecs[i].exp_err});
      if (!vecs[i].we || vecs[i].exp_err)
        check($sformatf("v%0d_rdata", i), rdata2, vecs[i].exp_rdata);
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), {31'b0, ready2}, 32'h0);
    end

    // Backdoor word and bus write land on index 5 in the same ACCESS cycle.
    issue(1'b1, 32'h14, 32'h0000BEEF, 4'b0011);
    @(negedge clk);
    @(negedge clk);
    init_we = 1'b1; init_idx = 6'd5; init_data = 32'hDEAD0000;
    @(negedge clk);
    init_we = 1'b0;
    check("collide_ready", {31'b0, ready2}, 32'h1);
    issue(1'b0, 32'h14, 32'h0, 4'h0);
    wait_ready(lat);
    check("collide_word", rdata2, 32'hDEADBEEF);

    // Reset during WAIT of a write to index 2.
    issue(1'b0, 32'h04, 32'h0, 4'h0);
    wait_ready(lat);
    check("pre_reset_rdata", rdata2, 32'h00000005);
    issue(1'b1, 32'h08, 32'hFFFFFFFF, 4'hF);
    check("abort_busy_before", {31'b0, busy2}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'b0, ready2}, 32'h0);
    check("abort_busy",  {31'b0, busy2},  32'h0);
    check("abort_err",   {31'b0, err2},   32'h0);
    check("abort_rdata", rdata2,          32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready2) cnt++;
    end
    check("abort_no_ready", cnt, 32'd0);
    issue(1'b0, 32'h08, 32'h0, 4'h0);
    wait_ready(lat);
    check("abort_word_kept", rdata2, 32'h0000000A);

    // Zero wait states, req held for six edges.
    we = 1'b0; addr = 32'h04; be = 4'h0;
    @(negedge clk);
    req0 = 1'b1;
    rdy_pat = '0; busy_pat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rdy_pat[i]  = ready0;
      busy_pat[i] = busy0;
      if (i == 5) req0 = 1'b0;
    end
    check("b2b_ready_pattern", {24'b0, rdy_pat},  32'h2A);
    check("b2b_busy_pattern",  {24'b0, busy_pat}, 32'h3F);
    check("b2b_rdata", rdata0, 32'h00000005);
    check("b2b_err", {31'b0, err0}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_ws.md
Name: dmem_ws

Overview:
- Parametrised successor to the single-cycle data memory behind computer_top.
- Adds configurable wait states, a req/ready handshake, byte-lane writes, and range/alignment error reporting.
- Adds a backdoor preload port, so benches no longer poke the RAM hierarchically.
- Sits between the processor load/store path and word storage; the processor stalls until ready.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- ADDR_W, 32, byte address width.
- DEPTH, 64, number of words stored.
- WAIT_CYCLES, 2, extra cycles between acceptance and response; 0 is legal.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request, sampled only in IDLE.
- we  in  1  1 = write, 0 = read; captured with req.
- addr  in  ADDR_W  byte address; captured with req.
- wdata  in  DATA_W  write data; captured with req.
- be  in  DATA_W/8  byte enables; be[i] covers wdata[8i+7:8i].
- ready  out  1  one-cycle response strobe.
- rdata  out  DATA_W  read data; valid when ready=1 and err=0.
- err  out  1  qualified by ready: misaligned or out-of-range access.
- busy  out  1  high from acceptance through the ready cycle.
- init_we  in  1  backdoor write strobe.
- init_idx  in  $clog2(DEPTH)  backdoor word index.
- init_data  in  DATA_W  backdoor word; full-word write, no byte enables.

Behaviour:
- Reset (reset=0, async): state=IDLE; ready=0, err=0, busy=0, rdata=0; wait counter=0.
  - RAM contents are not cleared.
  - An aborted write that had not reached ACCESS leaves RAM unchanged.
- FSM IDLE -> WAIT -> ACCESS -> IDLE.
  - IDLE: req=1 captures we/addr/wdata/be; busy=1 next cycle. Go to WAIT if WAIT_CYCLES>0, else ACCESS.
  - WAIT: counter runs 1..WAIT_CYCLES; go to ACCESS when counter==WAIT_CYCLES.
  - ACCESS: perform the access; drive ready=1 for exactly this cycle; return to IDLE.
- Latency: req sampled at edge N gives ready high in the cycle after edge N+WAIT_CYCLES+1.
  - For WAIT_CYCLES=0: request at edge 0, ready visible in cycle 1.
- Throughput: one access per WAIT_CYCLES+2 cycles. req during WAIT or ACCESS is ignored, not queued.
- Word index = addr[ADDR_W-1:log2(DATA_W/8)].
  - err=1 if the low byte-offset bits are nonzero, or index >= DEPTH.
  - On err: no RAM write; rdata=0.
- Write (ACCESS, we=1, no err): for each i with be[i]=1, RAM[index] byte i = wdata byte i; other bytes are kept.
  - be=0 is legal: no change, ready still asserted.
- Read (ACCESS, we=0, no err): rdata = RAM[index] as of the start of the ACCESS cycle.
  - rdata holds its value until the next ready; be is ignored.
- Read-after-write: a read accepted after a write's ready returns the new data.
- Backdoor: init_we writes RAM[init_idx] at the clock edge in any state.
  - Same index as an ACCESS write in the same cycle: bus write bytes win, non-enabled bytes take init_data.
  - init_idx >= DEPTH: ignored.
- Reset mid-operation: abort immediately; no ready is ever produced for the aborted request.

Decomposition:
- Package dmem_pkg:
  - state enum dmem_state_e {IDLE, WAIT, ACCESS};
  - function word_bytes(DATA_W);
  - localparam helpers for index and offset widths.
- Sub-module dmem_array: storage with one byte-enabled bus write port, one full-word backdoor port (with the merge rule above), and one async read port. The FSM, counter, and error check stay in dmem_ws.

Test Plan:
- Preload and read: init RAM[1]=0x00000005, RAM[2]=0x0000000A; read addr 0x4 then 0x8 with WAIT_CYCLES=2 -> ready 3 cycles after each req; rdata=0x5 then 0xA; err=0.
- Byte-lane write: RAM[3]=0x11223344; write addr 0xC, wdata=0xAABBCCDD, be=4'b0101, then read 0xC -> 0x11BB33DD.
- Errors: read addr 0x6 -> ready with err=1, rdata=0. Write addr 0x100 (index 64, DEPTH=64) -> err=1; RAM[0] unchanged.
- Zero wait and back-to-back: WAIT_CYCLES=0; req held high for 6 cycles with reads -> ready on alternate cycles (one access per 2 cycles); req ignored while busy=1.
- Reset mid-operation: write accepted, reset=0 in WAIT -> ready never asserts; all outputs 0 asynchronously; target word unchanged; next read after release returns the old value.
- Backdoor collision: ACCESS write be=4'b0011, wdata=0x0000BEEF, plus same-cycle init_data=0xDEAD0000 to the same index -> stored word 0xDEADBEEF.
